// File: rtl/mem_arb_pkg.sv
// Shared constants, the read-owner tag and the saturating-counter helper
// used by the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CONF_W = 16;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  function automatic logic [CONF_W-1:0] sat_inc(input logic [CONF_W-1:0] v);
    return (&v) ? v : v + CONF_W'(1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer remembers who
// was granted last so the other requester wins the next tie.
module rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_if,
  input  logic i_req_d,
  output logic o_gnt_if,
  output logic o_gnt_d
);

  logic r_last_d;

  // Grants are masked during reset so nothing reaches the RAM port.
  always_comb begin
    o_gnt_if = 1'b0;
    o_gnt_d  = 1'b0;
    if (i_rst_n) begin
      if (i_req_if && (!i_req_d || r_last_d)) o_gnt_if = 1'b1;
      else if (i_req_d)                       o_gnt_d  = 1'b1;
    end
  end

  // Reset value makes fetch win the first conflict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_last_d <= 1'b1;
    else if (o_gnt_if) r_last_d <= 1'b0;
    else if (o_gnt_d)  r_last_d <= 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between a fetch read port and a
// load/store data port, one access per cycle, read latency 1.
module mem_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            if_req,
  input  logic [ADDR_W-1:0]               if_addr,
  output logic                            if_gnt,
  output logic                            if_rvalid,
  output logic [DATA_W-1:0]               if_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [ADDR_W-1:0]               d_addr,
  input  logic [DATA_W-1:0]               d_wdata,
  output logic                            d_gnt,
  output logic                            d_rvalid,
  output logic [DATA_W-1:0]               d_rdata,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wdata,
  output logic                            ram_we,
  output logic                            ram_re,
  input  logic [DATA_W-1:0]               ram_rdata,
  output logic [mem_arb_pkg::CONF_W-1:0]  conflicts
);
  import mem_arb_pkg::*;

  logic              w_gnt_if;
  logic              w_gnt_d;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_pend_vld;
  owner_e            r_pend_own;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_d_hold;
  logic [CONF_W-1:0] r_conf;

  rr_arb2 u_arb (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_req_if (if_req),
    .i_req_d  (d_req),
    .o_gnt_if (w_gnt_if),
    .o_gnt_d  (w_gnt_d)
  );

  assign if_gnt = w_gnt_if;
  assign d_gnt  = w_gnt_d;
  assign ram_we = w_gnt_d & d_we;
  assign ram_re = w_gnt_if | (w_gnt_d & ~d_we);

  // Without a grant the RAM address/data bus parks on the last driven values.
  always_comb begin
    ram_addr  = r_addr;
    ram_wdata = r_wdata;
    if (w_gnt_if) begin
      ram_addr = if_addr;
    end else if (w_gnt_d) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_pend_vld <= 1'b0;
      r_pend_own <= OWN_IF;
      r_conf     <= '0;
    end else begin
      r_addr     <= ram_addr;
      r_wdata    <= ram_wdata;
      r_pend_vld <= ram_re;
      r_pend_own <= w_gnt_if ? OWN_IF : OWN_D;
      if (if_req && d_req) r_conf <= sat_inc(r_conf);
    end
  end

  assign if_rvalid = r_pend_vld && (r_pend_own == OWN_IF);
  assign d_rvalid  = r_pend_vld && (r_pend_own == OWN_D);

  // Per-port hold keeps rdata stable between that port's own rvalids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      if (if_rvalid) r_if_hold <= ram_rdata;
      if (d_rvalid)  r_d_hold  <= ram_rdata;
    end
  end

  assign if_rdata  = if_rvalid ? ram_rdata : r_if_hold;
  assign d_rdata   = d_rvalid  ? ram_rdata : r_d_hold;
  assign conflicts = r_conf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 512x32 synchronous RAM model and a
// scoreboard monitor for read data returned on each port.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [8:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [15:0] conflicts;

  logic [31:0] mem [512];
  logic [31:0] q_if [$];
  logic [31:0] q_d  [$];
  int checks;
  int errors;

  mem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .conflicts (conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, write visible to the next cycle's read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expected read data whenever a port presents rvalid
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (if_rvalid) begin
        if (q_if.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata, q_if.pop_front());
      end
      if (d_rvalid) begin
        if (q_d.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
        else chk("d_rdata", d_rdata, q_d.pop_front());
      end
    end
  end

  task automatic drive(input logic ir, input logic [8:0] ia, input logic dr,
                       input logic dw, input logic [8:0] da, input logic [31:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic step(input logic ir, input logic [8:0] ia, input logic dr,
                      input logic dw, input logic [8:0] da, input logic [31:0] dd,
                      input logic egi, input logic egd, input logic [8:0] ea,
                      input logic ere, input logic ewe);
    drive(ir, ia, dr, dw, da, dd);
    @(negedge clk);
    chk("if_gnt", 32'(if_gnt), 32'(egi));
    chk("d_gnt", 32'(d_gnt), 32'(egd));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_re", 32'(ram_re), 32'(ere));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    if (ewe) chk("ram_wdata", ram_wdata, dd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [8:0] ea);
    step(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, ea, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
    chk({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_re"}, 32'(ram_re), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk({tag, "_conflicts"}, 32'(conflicts), 32'd0);
  endtask

  // Requests are held high during reset to show that grants stay masked
  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b1, 9'd104, 1'b1, 1'b1, 9'd82, 32'hAA);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[104] = 32'h55;
    mem[82]  = 32'h26;
    @(posedge clk);
    #1;
    do_reset();

    // Fetch-only read
    q_if.push_back(32'h55);
    step(1'b1, 9'd104, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 9'd104, 1'b1, 1'b0);
    idle(9'd104);
    chk("if_rdata_hold", if_rdata, 32'h55);

    // Simultaneous requests right after reset: fetch first
    do_reset();
    q_if.push_back(32'h26);
    q_d.push_back(32'h55);
    step(1'b1, 9'd82, 1'b1, 1'b0, 9'd104, 32'd0, 1'b1, 1'b0, 9'd82, 1'b1, 1'b0);
    step(1'b0, 9'd0, 1'b1, 1'b0, 9'd104, 32'd0, 1'b0, 1'b1, 9'd104, 1'b1, 1'b0);
    idle(9'd104);
    chk("conflicts_one", 32'(conflicts), 32'd1);
    chk("if_rdata_held", if_rdata, 32'h26);

    // Store then read-after-write of the same address
    step(1'b0, 9'd0, 1'b1, 1'b1, 9'd82, 32'h2F, 1'b0, 1'b1, 9'd82, 1'b0, 1'b1);
    q_if.push_back(32'h2F);
    step(1'b1, 9'd82, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 9'd82, 1'b1, 1'b0);
    idle(9'd82);
    chk("d_rdata_unchanged_by_store", d_rdata, 32'h55);

    // Fetch-first start, then six conflict cycles alternating D,I,D,I,D,I
    do_reset();
    q_if.push_back(32'h55);
    step(1'b1, 9'd104, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 9'd104, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        q_d.push_back(32'h2F);
        step(1'b1, 9'd104, 1'b1, 1'b0, 9'd82, 32'd0, 1'b0, 1'b1, 9'd82, 1'b1, 1'b0);
      end else begin
        q_if.push_back(32'h55);
        step(1'b1, 9'd104, 1'b1, 1'b0, 9'd82, 32'd0, 1'b1, 1'b0, 9'd104, 1'b1, 1'b0);
      end
    end
    idle(9'd104);
    chk("conflicts_six", 32'(conflicts), 32'd6);
    chk("q_if_drained_alt", 32'(q_if.size()), 32'd0);
    chk("q_d_drained_alt", 32'(q_d.size()), 32'd0);

    // Reset in the cycle after a read grant discards that read
    step(1'b1, 9'd104, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 9'd104, 1'b1, 1'b0);
    reset_n = 1'b0;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clk);
    check_all_zero("midread");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(9'd0);
    idle(9'd0);
    q_if.push_back(32'h2F);
    step(1'b1, 9'd82, 1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 9'd82, 1'b1, 1'b0);
    idle(9'd82);

    // Long conflict run: fetch gets every other slot, counter saturates
    for (int i = 0; i < 35000; i++) q_if.push_back(32'h55);
    drive(1'b1, 9'd104, 1'b1, 1'b1, 9'd200, 32'd0);
    repeat (70000) @(posedge clk);
    #1;
    idle(9'd104);
    chk("conflicts_sat", 32'(conflicts), 32'h0000FFFF);

    chk("q_if_empty", 32'(q_if.size()), 32'd0);
    chk("q_d_empty", 32'(q_d.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDR_W  9   RAM word-address width (512 words)
  DATA_W  32  RAM data width
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk        in   1       single clock, rising edge
  reset_n    in   1       asynchronous active-low reset
  if_req     in   1       fetch read request; held with if_addr until granted
  if_addr    in   ADDR_W  fetch word address
  if_gnt     out  1       fetch request accepted this cycle
  if_rvalid  out  1       fetch read data valid this cycle
  if_rdata   out  DATA_W  fetch read data
  d_req      in   1       data-port request; held with d_we/d_addr/d_wdata until granted
  d_we       in   1       1 = store, 0 = load
  d_addr     in   ADDR_W  data word address
  d_wdata    in   DATA_W  store data
  d_gnt      out  1       data request accepted this cycle
  d_rvalid   out  1       load data valid this cycle
  d_rdata    out  DATA_W  load data
  ram_addr   out  ADDR_W  to RAM address
  ram_wdata  out  DATA_W  to RAM write data
  ram_we     out  1       to RAM write_enable
  ram_re     out  1       to RAM read_enable
  ram_rdata  in   DATA_W  from RAM; registered, valid 1 cycle after ram_re
  conflicts  out  16      saturating count of cycles with if_req and d_req both high

Function
REQ-003 At most one grant per cycle; grant is combinational from req and the round-robin pointer.
REQ-004 Only one requester: it is granted immediately.
REQ-005 Both requesting: the port not granted most recently wins; the pointer updates on every grant.
REQ-006 On grant, ram_addr, ram_we and ram_re reflect the granted request in the same cycle. ram_re = granted and not a store; ram_we = granted data store.
REQ-007 No grant: ram_we = 0, ram_re = 0, and ram_addr/ram_wdata hold their previous values.
REQ-008 Read latency is 1.
  - A read granted in cycle T raises that port's rvalid in T+1 with rdata = ram_rdata.
  - A pending-read register {valid, owner} tracks the owner.
REQ-009 Back-to-back grants are allowed: throughput is 1 access/cycle with no bubble between read→read, read→write or write→read.
REQ-010 Stores produce no rvalid; d_gnt alone completes a store.
REQ-011 Write in T followed by a read of the same address in T+1 returns the new data.
REQ-012 Each rdata output holds its last valid value between rvalids: per-port hold register loaded on rvalid; output = rvalid ? ram_rdata : hold.
REQ-013 conflicts increments on each cycle with both req high and saturates at 0xFFFF.
REQ-014 A requester that drops req before grant is treated as never requesting; no error is flagged.

Reset
REQ-015 While reset_n is low, the following are forced asynchronously to 0, and the pointer favours fetch on the first conflict:
  - all gnt/rvalid/ram_we/ram_re outputs;
  - ram_addr, ram_wdata, rdata holds, conflicts;
  - pending-read register.
REQ-016 Reset asserted with a read outstanding discards that read; no rvalid is produced after reset_n rises.

Structure
REQ-017 Package mem_arb_pkg holds ADDR_W, DATA_W and the owner enum {OWN_IF, OWN_D}.
REQ-018 Sub-module rr_arb2 contains the 2-way round-robin grant logic and pointer; everything else is in mem_arbiter.

Verification
REQ-019 The bench instantiates mem_arbiter with the existing 512×32 RAM model, preloaded mem[104]=0x55 and mem[82]=0x26, and covers:
  - Fetch-only read addr 104 → if_gnt same cycle, if_rvalid next cycle, if_rdata=0x55, d_rvalid stays 0.
  - Both request in the same cycle after reset (if addr 82, d load addr 104) → fetch granted first, data granted next cycle; if_rdata=0x26 in T+1, d_rdata=0x55 in T+2; conflicts=1.
  - Data store 0x2F to 82 in T, fetch read 82 in T+1 → if_rdata=0x2F in T+2; no d_rvalid.
  - Continuous conflict for 6 cycles → grants alternate D,I,D,I,D,I after a fetch-first start; conflicts=6; no lost or duplicated rvalid.
  - reset_n pulled low in the cycle after a read grant → rvalid never asserts; all outputs 0; first post-reset read returns correct data.
  - Force 70000 conflict cycles → conflicts saturates at 0xFFFF.
